shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
Multi-cycle shift unit for the RISC-V core. Executes SLL/SRL/SRA (and immediate forms) one bit position per cycle, reusing a single-bit shift datapath instead of a full barrel shifter. Sits beside the EX-stage ALU. The pipeline stalls on in_ready/out_valid via a valid/ready handshake on both sides.

Parameters:
XLEN, 32, operand/result width in bits
SHW, 5, shift-amount width; must equal $clog2(XLEN)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous abort of any in-flight operation (branch mispredict)
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request
in_op  in  2  00 SLL, 01 SRL, 11 SRA, 10 reserved
in_data  in  XLEN  operand rs1
in_shamt  in  SHW  shift amount (rs2[SHW-1:0] or imm)
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts result
out_data  out  XLEN  shifted result
busy  out  1  high in SHIFT or DONE

Behaviour:
- Reset (rst=0, async): state=IDLE; in_ready=1; out_valid=0; out_data=0; busy=0; internal count/op cleared.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch data, op and count=in_shamt.
  - count!=0 and op!=10: go to SHIFT.
  - otherwise: go to DONE with the result equal to in_data.
- SHIFT: each cycle, shift the working register by one bit and decrement count.
  - SLL: shift left with 0 fill.
  - SRL: shift right with 0 fill.
  - SRA: shift right, replicating the MSB.
  - When the post-decrement count==0, go to DONE.
- DONE: out_valid=1 and out_data stable. On out_ready, go to IDLE. The next request is accepted no earlier than the following cycle; there is no same-cycle back-to-back.
- Latency from accept edge to out_valid: shamt=0 gives 1 cycle; shamt=k gives k+1 cycles (max XLEN).
- in_ready=0 whenever state!=IDLE. Requests presented while busy are ignored, not queued.
- out_data changes only on the transition into DONE or on reset. It holds its last value in IDLE.
- flush: any state goes to IDLE next cycle with out_valid=0. flush has priority over out_ready and over a new accept in the same cycle. No result is produced for a flushed op.
- Simultaneous flush and in_valid in IDLE: the request is dropped.
- Reset mid-SHIFT: immediate return to reset values; the partial result is discarded.
- Reserved op 10: pass-through, 1-cycle latency, no error flag.
- Width rules: shamt is unsigned, only SHW bits used (RV32 semantics). The working register is XLEN bits; bits shifted out are lost.

Optional Feature:
Macro SHIFT_SEQ_FAST_EN.
- Defined: in SHIFT, when count>=4, shift by 4 positions and decrement by 4; otherwise shift by 1. Latency for shamt=k becomes floor(k/4)+(k mod 4)+1, so shamt=31 takes 11 cycles.
- Undefined: strictly 1 bit per cycle, k+1 latency. All handshake and flush rules are identical in both builds.

Decomposition:
- Package shift_seq_pkg holds:
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b11, OP_RSV=2'b10
  - state encoding: IDLE/SHIFT/DONE, 2 bits
  - step constants: STEP_1=1, STEP_4=4
- One combinational sub-module, shift_step:
  - inputs: XLEN data, op, a step-select bit
  - output: the one-step (or 4-step) shifted word
  - instantiated once inside the sequencer; the FSM and counter stay in shift_sequencer.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release → in_ready=1, out_valid=0, out_data=0, busy=0.
- SLL: data=0x0000_0001, shamt=4, op=00 → out_valid 5 cycles after accept, out_data=0x0000_0010; out_ready=0 for 3 cycles keeps the value stable.
- SRA: data=0x8000_0000, shamt=31, op=11 → out_data=0xFFFF_FFFF after 32 cycles; SRL with the same inputs → 0x0000_0001.
- Zero shift/reserved: shamt=0, data=0xDEAD_BEEF → out_valid next cycle, out_data=0xDEAD_BEEF; op=10, shamt=7 → same passthrough.
- Flush: SLL shamt=20, assert flush on cycle 6 → out_valid never rises, in_ready=1 next cycle; in_valid asserted while busy is ignored.
- Fast build (SHIFT_SEQ_FAST_EN): SRL data=0xF000_0000, shamt=31 → out_data=0x0000_0001 after 11 cycles.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared encodings for the multi-cycle shift sequencer: op codes, FSM states, step sizes.
package shift_seq_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_RSV = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  localparam int unsigned STEP_1 = 1;
  localparam int unsigned STEP_4 = 4;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake bundle between the EX stage and the shift sequencer.
interface shift_sequencer_if #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
);
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_data;
  logic [SHW-1:0]  in_shamt;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;

  modport master (
    output in_valid, in_op, in_data, in_shamt, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_data, in_shamt, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_sequencer_shift_step.sv
// Combinational single step of the shift datapath: moves the word by 1 or 4 positions.
module shift_step
  import shift_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      op,
  input  logic            step4,
  output logic [XLEN-1:0] shifted
);

  logic [2:0] amt;

  assign amt = step4 ? 3'(STEP_4) : 3'(STEP_1);

  always_comb begin
    shifted = data;
    case (op)
      OP_SLL:  shifted = data << amt;
      OP_SRL:  shifted = data >> amt;
      OP_SRA:  shifted = $unsigned($signed(data) >>> amt);
      default: shifted = data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA unit reusing one shift step per cycle.
// Optional SHIFT_SEQ_FAST_EN: take 4-position steps while at least 4 remain.
//
// state | meaning
// IDLE  | ready for a request, out_data holds last result
// SHIFT | working register stepping, count = positions left
// DONE  | result presented, waiting for out_ready
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  shift_sequencer_if.slave    bus,
  output logic                busy
);

  state_t          state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [SHW-1:0]  count_q, count_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] step_out;
  logic            step4;
  logic [SHW-1:0]  step_amt;

`ifdef SHIFT_SEQ_FAST_EN
  assign step4 = (count_q >= SHW'(STEP_4));
`else
  assign step4 = 1'b0;
`endif

  assign step_amt = step4 ? SHW'(STEP_4) : SHW'(STEP_1);

  shift_step #(.XLEN(XLEN)) u_step (
    .data    (work_q),
    .op      (op_q),
    .step4   (step4),
    .shifted (step_out)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
      op_q    <= OP_SLL;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    work_d        = work_q;
    count_d       = count_q;
    op_d          = op_q;
    res_d         = res_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;

    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          work_d  = bus.in_data;
          op_d    = bus.in_op;
          count_d = bus.in_shamt;
          if (bus.in_shamt != '0 && bus.in_op != OP_RSV) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
            res_d   = bus.in_data;
          end
        end
      end
      SHIFT: begin
        busy    = 1'b1;
        work_d  = step_out;
        count_d = count_q - step_amt;
        if (count_d == '0) begin
          state_d = DONE;
          res_d   = step_out;
        end
      end
      DONE: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over accept and completion; the visible result must not move.
    if (flush) begin
      state_d = IDLE;
      res_d   = res_q;
    end
  end

  assign bus.out_data = res_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic busy;

  int n_cmp = 0;
  int n_err = 0;

  shift_sequencer_if #(.XLEN(32), .SHW(5)) bus ();

  shift_sequencer #(.XLEN(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] d,
                                             input int k);
    logic signed [31:0] s;
    s = d;
    case (op)
      2'b00:   return d << k;
      2'b01:   return d >> k;
      2'b11:   return s >>> k;
      default: return d;
    endcase
  endfunction

  function automatic int ref_latency(input logic [1:0] op, input int k);
    if (op == 2'b10 || k == 0) return 1;
`ifdef SHIFT_SEQ_FAST_EN
    return k / 4 + k % 4 + 1;
`else
    return k + 1;
`endif
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] data, input logic [4:0] shamt,
                        input int hold);
    logic [31:0] exp;
    int lat;
    int n;
    exp = ref_result(op, data, int'(shamt));
    lat = ref_latency(op, int'(shamt));
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = data;
    bus.in_shamt = shamt;
    bus.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n = 1;
    if (lat > 1) begin
      chk("busy_shift", 32'(busy), 32'd1);
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      // Request while busy must be ignored.
      bus.in_valid = 1'b1;
      bus.in_data  = $urandom;
      bus.in_shamt = 5'($urandom);
      bus.in_op    = 2'($urandom);
    end else begin
      bus.in_valid = 1'b0;
    end
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      n++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 32'(n), 32'(lat));
    chk("result", bus.out_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", bus.out_data, exp);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_valid", 32'(bus.out_valid), 32'd0);
    chk("release_ready", 32'(bus.in_ready), 32'd1);
    chk("release_busy", 32'(busy), 32'd0);
    chk("idle_data", bus.out_data, exp);
  endtask

  initial begin
    int saw_valid;
    logic [1:0] rop;
    rst = 1'b0;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_op = 2'b00;
    bus.in_data = '0;
    bus.in_shamt = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    run_op(2'b00, 32'h0000_0001, 5'd4, 3);
    run_op(2'b11, 32'h8000_0000, 5'd31, 0);
    run_op(2'b01, 32'h8000_0000, 5'd31, 1);
    run_op(2'b00, 32'hDEAD_BEEF, 5'd0, 1);
    run_op(2'b10, 32'hDEAD_BEEF, 5'd7, 1);
    run_op(2'b01, 32'hF000_0000, 5'd31, 0);
    run_op(2'b11, 32'h7FFF_FFFF, 5'd1, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 5'd3, 0);

    // Flush mid-shift: the op vanishes without a result.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = 2'b00;
    bus.in_data = 32'h1234_5678;
    bus.in_shamt = 5'd20;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_data_kept", bus.out_data, 32'hFFFF_FFFF >> 3);
    saw_valid = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid++;
    end
    chk("flush_no_result", 32'(saw_valid), 32'd0);

    // Flush in DONE beats out_ready.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = 2'b01;
    bus.in_data = 32'hCAFE_0001;
    bus.in_shamt = 5'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("done_valid", 32'(bus.out_valid), 32'd1);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    bus.out_ready = 1'b0;
    chk("flush_done_valid", 32'(bus.out_valid), 32'd0);
    chk("flush_done_ready", 32'(bus.in_ready), 32'd1);
    chk("flush_done_data", bus.out_data, 32'hCAFE_0001);

    // Flush with a request in IDLE drops the request.
    bus.in_valid = 1'b1;
    bus.in_op = 2'b00;
    bus.in_data = 32'h0000_00FF;
    bus.in_shamt = 5'd2;
    flush = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    flush = 1'b0;
    chk("drop_busy", 32'(busy), 32'd0);
    saw_valid = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid++;
    end
    chk("drop_no_result", 32'(saw_valid), 32'd0);

    // Reset mid-shift discards everything.
    run_op(2'b00, 32'h0000_0003, 5'd2, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_op = 2'b00;
    bus.in_data = 32'h0000_0001;
    bus.in_shamt = 5'd25;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_data", bus.out_data, 32'd0);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom);
      run_op(rop, $urandom, 5'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
